disp_demux: RTL and testbench
=============================

// Module: disp_demux
// PURPOSE
//  Receive end of the 4-digit multiplexed seven-segment bus (an one-hot active-high, sseg 8 bit).
//  Samples a scanned an/sseg pair, applies a stability filter, and rebuilds the four digit
//  patterns as static registers. Also produces per-digit valid flags, a frame strobe and bus faults.
//  Used as a display-bus monitor: board loopback, capture into a second display or logic analyser,
//  and self-check of the display mux.
// PARAMETERS
//  STABLE_CYCLES  16  consecutive identical synced samples required to latch a digit (>=2)
//  TO_W           20  watchdog width; bus is stale after 2**TO_W-1 cycles with no latch
// PORTS
//  clk        in   1  system clock
//  reset      in   1  asynchronous, active-high reset
//  an_in      in   4  digit enables from bus, one-hot active-high, bit k = digit k
//  sseg_in    in   8  segment bus, valid for the enabled digit
//  dig0       out  8  last latched pattern for digit 0
//  dig1       out  8  last latched pattern for digit 1
//  dig2       out  8  last latched pattern for digit 2
//  dig3       out  8  last latched pattern for digit 3
//  dig_vld    out  4  bit k set once digit k latched; cleared by reset or stale
//  frame_stb  out  1  1-cycle pulse when all 4 digits latched since previous pulse
//  err_multi  out  1  1-cycle pulse on entry to FAULT (more than one an bit set)
//  stale      out  1  level; watchdog expired, cleared on next latch
// BEHAVIOUR
//  Reset: dig0..3=8'h00, dig_vld=0, frame_stb=0, err_multi=0, stale=0, FSM=BLANK, counters=0.
//  Synchronisation:
//   - an_in and sseg_in each pass through a 2-flop synchroniser -> an_s, sseg_s.
//   - prev registers hold last cycle's an_s/sseg_s; same = (an_s==an_p)&&(sseg_s==sseg_p).
//  Class of an_s: ZERO (4'b0000), ONE (exactly one bit set), MULTI (>=2 bits set).
//  FSM, evaluated every cycle; priority: class change, then same:
//   - BLANK:
//     - ONE -> DWELL, cnt=1.
//     - MULTI -> FAULT.
//     - ZERO -> stay.
//   - DWELL:
//     - ZERO -> BLANK.
//     - MULTI -> FAULT.
//     - ONE & !same -> DWELL, cnt=1 (restart).
//     - ONE & same & cnt==STABLE_CYCLES-1 -> latch, go HELD.
//     - ONE & same, otherwise -> cnt+1.
//   - HELD:
//     - ZERO -> BLANK.
//     - MULTI -> FAULT.
//     - ONE & !same -> DWELL, cnt=1.
//     - ONE & same -> stay; no re-latch.
//   - FAULT:
//     - ZERO -> BLANK.
//     - ONE -> DWELL, cnt=1.
//     - MULTI -> stay.
//     - err_multi pulses only on the entry cycle.
//  Latch (registered):
//   - dig[k] <= sseg_s and dig_vld[k] <= 1, for the k with an_s[k]=1.
//   - seen[k] <= 1.
//   - watchdog <= 0, stale <= 0.
//  Latency: a pattern held STABLE_CYCLES+2 clocks after an_in/sseg_in settle is visible on dig[k].
//  Frame:
//   - If a latch makes seen==4'hF, frame_stb=1 on the same edge the dig update appears.
//   - seen is cleared to 4'h0 on that edge.
//   - A digit re-latched before frame completion overwrites dig[k]; seen is unchanged.
//  Watchdog:
//   - Increments each cycle without a latch, saturating at all-ones.
//   - On reaching all-ones: stale=1, dig_vld=0, seen=0; dig registers keep their values.
//  Reset mid-operation: all state returns to reset values immediately (asynchronous);
//   synchroniser flops also reset to 0.
//  Widths: cnt is $clog2(STABLE_CYCLES+1) bits and never wraps; watchdog is TO_W bits, saturating.
// TESTING
//  T1 Nominal scan:
//     - Stimulus: STABLE_CYCLES=16; drive an=0001/0010/0100/1000 with sseg=8'hC0,F9,A4,B0, 64 clk each.
//     - Response: dig0..3=C0,F9,A4,B0; dig_vld=4'hF; one frame_stb per 4-digit scan.
//  T2 Glitch reject:
//     - Stimulus: an=0010, sseg=8'h99 for 10 clk, then 8'h92 for 30 clk.
//     - Response: 8'h99 never latched; dig1=8'h92 exactly 18 clk after the change.
//  T3 Multi-hot:
//     - Stimulus: an=0110 for 40 clk, then an=0100.
//     - Response: exactly one err_multi pulse; no latch during 0110; dig2 latches after the filter.
//  T4 Blanking gaps:
//     - Stimulus: insert an=0000 for 5 clk between digits.
//     - Response: no error; frame_stb still pulses once per scan.
//  T5 Stale:
//     - Stimulus: TO_W=8; hold an=0000 after a frame.
//     - Response: stale=1 and dig_vld=0 at 255 clk after the last latch; both recover on the next latch.
//  T6 Reset mid-dwell:
//     - Stimulus: assert reset at cnt=10.
//     - Response: all outputs go to reset values the same cycle; after release, a full STABLE_CYCLES is needed to latch.

Source files
------------

// File: rtl/disp_demux.sv
// disp_demux: receive end of a 4-digit multiplexed seven-segment bus.
// Synchronises the scanned an/sseg pair and filters it for stability. It then rebuilds the four
// digit patterns as static registers, with per-digit valid flags, a frame strobe and bus faults.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   an_in      one-hot active-high digit enables, bit k = digit k
//   sseg_in    segment bus, valid for the enabled digit
//   dig0..dig3 last latched pattern per digit
//   dig_vld    bit k set once digit k latched; cleared by reset or stale
//   frame_stb  1-cycle pulse when all four digits latched since the previous pulse
//   err_multi  1-cycle pulse on entry to the fault state (more than one an bit set)
//   stale      watchdog expired; cleared on the next latch
module disp_demux #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned TO_W          = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] an_in,
    input  logic [7:0] sseg_in,
    output logic [7:0] dig0,
    output logic [7:0] dig1,
    output logic [7:0] dig2,
    output logic [7:0] dig3,
    output logic [3:0] dig_vld,
    output logic       frame_stb,
    output logic       err_multi,
    output logic       stale
);

    localparam int unsigned     CntW    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);
    localparam logic [TO_W-1:0] WdMax   = '1;

    typedef enum logic [1:0] {StBlank, StDwell, StHeld, StFault} state_e;

    state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [3:0]      an_m_q, an_s_q, an_p_q;
    logic [7:0]      sseg_m_q, sseg_s_q, sseg_p_q;
    logic [3:0][7:0] dig_q;
    logic [3:0]      vld_q, seen_q;
    logic [TO_W-1:0] wd_q;
    logic            frame_q, err_q, stale_q;

    logic same, is_zero, is_one, is_multi;
    logic latch, fault_entry;

    assign same     = (an_s_q == an_p_q) && (sseg_s_q == sseg_p_q);
    assign is_zero  = (an_s_q == 4'b0000);
    assign is_one   = $onehot(an_s_q);
    assign is_multi = !is_zero && !is_one;

    // Two-flop synchronisers plus the previous-sample registers used for the stability compare.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_m_q   <= '0;
            an_s_q   <= '0;
            an_p_q   <= '0;
            sseg_m_q <= '0;
            sseg_s_q <= '0;
            sseg_p_q <= '0;
        end else begin
            an_m_q   <= an_in;
            an_s_q   <= an_m_q;
            an_p_q   <= an_s_q;
            sseg_m_q <= sseg_in;
            sseg_s_q <= sseg_m_q;
            sseg_p_q <= sseg_s_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StBlank;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state: bus class decides first, then sample stability.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StBlank: begin
                if (is_one) begin
                    state_d = StDwell;
                    cnt_d   = CntOne;
                end else if (is_multi) begin
                    state_d = StFault;
                end
            end
            StDwell: begin
                if (is_zero) begin
                    state_d = StBlank;
                end else if (is_multi) begin
                    state_d = StFault;
                end else if (!same) begin
                    cnt_d = CntOne;
                end else if (cnt_q == CntLast) begin
                    state_d = StHeld;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StHeld: begin
                if (is_zero) begin
                    state_d = StBlank;
                end else if (is_multi) begin
                    state_d = StFault;
                end else if (!same) begin
                    state_d = StDwell;
                    cnt_d   = CntOne;
                end
            end
            StFault: begin
                if (is_zero) begin
                    state_d = StBlank;
                end else if (is_one) begin
                    state_d = StDwell;
                    cnt_d   = CntOne;
                end
            end
            default: state_d = StBlank;
        endcase
    end

    // FSM outputs.
    always_comb begin
        latch       = (state_q == StDwell) && is_one && same && (cnt_q == CntLast);
        fault_entry = (state_d == StFault) && (state_q != StFault);
    end

    // Digit registers, frame tracking and watchdog.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dig_q   <= '0;
            vld_q   <= '0;
            seen_q  <= '0;
            wd_q    <= '0;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
            stale_q <= 1'b0;
        end else begin
            err_q   <= fault_entry;
            frame_q <= 1'b0;
            if (latch) begin
                for (int k = 0; k < 4; k++) begin
                    if (an_s_q[k]) begin
                        dig_q[k] <= sseg_s_q;
                    end
                end
                vld_q   <= vld_q | an_s_q;
                wd_q    <= '0;
                stale_q <= 1'b0;
                if ((seen_q | an_s_q) == 4'hF) begin
                    seen_q  <= '0;
                    frame_q <= 1'b1;
                end else begin
                    seen_q <= seen_q | an_s_q;
                end
            end else if (wd_q != WdMax) begin
                wd_q <= wd_q + 1'b1;
                // Expiry lands on the edge the counter reaches all-ones; patterns are kept.
                if (wd_q == WdMax - 1'b1) begin
                    stale_q <= 1'b1;
                    vld_q   <= '0;
                    seen_q  <= '0;
                end
            end
        end
    end

    assign dig0      = dig_q[0];
    assign dig1      = dig_q[1];
    assign dig2      = dig_q[2];
    assign dig3      = dig_q[3];
    assign dig_vld   = vld_q;
    assign frame_stb = frame_q;
    assign err_multi = err_q;
    assign stale     = stale_q;

endmodule

// File: tb/tb_disp_demux.sv
// tb_disp_demux: directed vector table for scans, gaps and multi-hot, plus hand sequences for
// glitch timing, watchdog expiry and reset mid-dwell.
module tb_disp_demux;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] an_in = 4'b0000;
    logic [7:0] sseg_in = 8'h00;
    logic [7:0] dig0, dig1, dig2, dig3;
    logic [3:0] dig_vld;
    logic       frame_stb, err_multi, stale;

    int n_pass = 0;
    int n_total = 0;

    disp_demux #(
        .STABLE_CYCLES(16),
        .TO_W(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .an_in    (an_in),
        .sseg_in  (sseg_in),
        .dig0     (dig0),
        .dig1     (dig1),
        .dig2     (dig2),
        .dig3     (dig3),
        .dig_vld  (dig_vld),
        .frame_stb(frame_stb),
        .err_multi(err_multi),
        .stale    (stale)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  an;
        logic [7:0]  sseg;
        int          cycles;
        logic [31:0] dig;     // {dig3, dig2, dig1, dig0} at the end of the vector
        logic [3:0]  vld;
        int          frames;
        int          errs;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles until dig[k] shows pat, or -1 if the bound expires.
    task automatic wait_dig(input int k, input logic [7:0] pat, input int bound, output int n);
        logic [31:0] d;
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            tick();
            d = {dig3, dig2, dig1, dig0};
            if (d[k*8 +: 8] == pat) begin
                n = i;
                break;
            end
        end
    endtask

    function automatic logic [31:0] all_out();
        return {dig3, dig2, dig1, dig0};
    endfunction

    initial begin
        int frames, errs, n, saw99;

        vecs[0]  = '{4'b0001, 8'hC0, 64, 32'h000000C0, 4'h1, 0, 0};
        vecs[1]  = '{4'b0010, 8'hF9, 64, 32'h0000F9C0, 4'h3, 0, 0};
        vecs[2]  = '{4'b0100, 8'hA4, 64, 32'h00A4F9C0, 4'h7, 0, 0};
        vecs[3]  = '{4'b1000, 8'hB0, 64, 32'hB0A4F9C0, 4'hF, 1, 0};
        vecs[4]  = '{4'b0000, 8'h00, 5,  32'hB0A4F9C0, 4'hF, 0, 0};
        vecs[5]  = '{4'b0001, 8'h81, 64, 32'hB0A4F981, 4'hF, 0, 0};
        vecs[6]  = '{4'b0000, 8'h00, 5,  32'hB0A4F981, 4'hF, 0, 0};
        vecs[7]  = '{4'b0010, 8'h82, 64, 32'hB0A48281, 4'hF, 0, 0};
        vecs[8]  = '{4'b0000, 8'h00, 5,  32'hB0A48281, 4'hF, 0, 0};
        vecs[9]  = '{4'b0100, 8'h83, 64, 32'hB0838281, 4'hF, 0, 0};
        vecs[10] = '{4'b0000, 8'h00, 5,  32'hB0838281, 4'hF, 0, 0};
        vecs[11] = '{4'b1000, 8'h84, 64, 32'h84838281, 4'hF, 1, 0};
        vecs[12] = '{4'b0110, 8'h55, 40, 32'h84838281, 4'hF, 0, 1};
        vecs[13] = '{4'b0100, 8'h66, 64, 32'h84668281, 4'hF, 0, 0};

        // Reset state.
        repeat (3) tick();
        check("reset_dig", all_out(), 32'h0);
        check("reset_flags", {28'h0, dig_vld}, 32'h0);
        check("reset_pulses", {29'h0, frame_stb, err_multi, stale}, 32'h0);
        reset = 1'b0;

        // Scans, blanking gaps and multi-hot.
        for (int v = 0; v < 14; v++) begin
            an_in   = vecs[v].an;
            sseg_in = vecs[v].sseg;
            frames  = 0;
            errs    = 0;
            for (int c = 0; c < vecs[v].cycles; c++) begin
                tick();
                if (frame_stb) frames++;
                if (err_multi) errs++;
            end
            check($sformatf("v%0d_dig", v), all_out(), vecs[v].dig);
            check($sformatf("v%0d_vld", v), {28'h0, dig_vld}, {28'h0, vecs[v].vld});
            check($sformatf("v%0d_frames", v), frames, vecs[v].frames);
            check($sformatf("v%0d_errs", v), errs, vecs[v].errs);
        end

        // Glitch reject: short 8'h99 never latches, 8'h92 lands 18 cycles after the change.
        an_in   = 4'b0010;
        sseg_in = 8'h99;
        saw99   = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (dig1 == 8'h99) saw99++;
        end
        sseg_in = 8'h92;
        n = -1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (dig1 == 8'h99) saw99++;
            if (dig1 == 8'h92 && n < 0) n = c;
        end
        check("glitch_latency", n, 18);
        check("glitch_no99", saw99, 0);

        // Watchdog: stale 255 cycles after the last latch, recovers on the next latch.
        an_in   = 4'b1000;
        sseg_in = 8'hB7;
        wait_dig(3, 8'hB7, 40, n);
        check("stale_pre_latch", n, 18);
        an_in   = 4'b0000;
        sseg_in = 8'h00;
        n = -1;
        for (int c = 1; c <= 300; c++) begin
            tick();
            if (stale) begin
                n = c;
                break;
            end
        end
        check("stale_time", n, 255);
        check("stale_vld", {28'h0, dig_vld}, 32'h0);
        check("stale_dig_kept", {24'h0, dig3}, 32'hB7);
        an_in   = 4'b0001;
        sseg_in = 8'hC3;
        wait_dig(0, 8'hC3, 40, n);
        check("recover_latency", n, 18);
        check("recover_stale", {31'h0, stale}, 32'h0);
        check("recover_vld", {28'h0, dig_vld}, 32'h1);

        // Reset mid-dwell at cnt=10, then a full filter period is needed again.
        an_in   = 4'b0100;
        sseg_in = 8'h5A;
        repeat (12) tick();
        #2 reset = 1'b1;
        #1;
        check("midrst_dig", all_out(), 32'h0);
        check("midrst_flags", {24'h0, dig_vld, 1'b0, frame_stb, err_multi, stale}, 32'h0);
        #2 reset = 1'b0;
        wait_dig(2, 8'h5A, 40, n);
        check("midrst_relatch", n, 18);
        check("midrst_vld", {28'h0, dig_vld}, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
